// File: rtl/pcu_pkg.sv
// Shared definitions for the program control unit: bus source select
// codes, bus handshake FSM states and the datapath width.
package pcu_pkg;

   localparam int PC_W = 8;

   typedef enum logic [2:0] {
      SEL_MDR  = 3'd0,
      SEL_PC   = 3'd1,
      SEL_ALU  = 3'd2,
      SEL_MEM  = 3'd3,
      SEL_ZERO = 3'd4
   } mux_sel_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } bus_state_e;

endpackage

// File: rtl/pcu_bus_fsm.sv
// Memory handshake FSM for the program control unit. Runs one access per
// C6 pulse, counts wait states, flags a sticky timeout and holds the
// datapath (stall) from the first access cycle through the turnaround.
module pcu_bus_fsm
   import pcu_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic C6,
   input  logic mem_we_sel,
   input  logic mem_ready,
   output logic mem_req,
   output logic mem_we,
   output logic stall,
   output logic bus_err,
   output logic mdr_load
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   bus_state_e state;
   logic [3:0] wait_cnt;

   // Handshake sequencing: all outputs except the MDR capture strobe are
   // registered alongside the state so they change only on clock edges
   // (or immediately on reset).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         stall    <= 1'b0;
         bus_err  <= 1'b0;
         wait_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (C6) begin
                  state    <= ACCESS;
                  mem_req  <= 1'b1;
                  mem_we   <= mem_we_sel;
                  stall    <= 1'b1;
                  wait_cnt <= 4'd0;
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
               end else if (wait_cnt + 4'd1 == WAIT_LIMIT) begin
                  state    <= DONE;
                  mem_req  <= 1'b0;
                  bus_err  <= 1'b1;
                  wait_cnt <= wait_cnt + 4'd1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            DONE: begin
               state  <= IDLE;
               stall  <= 1'b0;
               mem_we <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               stall   <= 1'b0;
            end
         endcase
      end
   end

   // Read data is captured on the edge that completes a read access.
   assign mdr_load = (state == ACCESS) && mem_ready && !mem_we;

endmodule

// File: rtl/pcu_ctrl.sv
// Program control unit top: PC, MAR, MDR and the TDB source mux, with
// the memory handshake delegated to pcu_bus_fsm.
// Optional macro PCU_COND_BRANCH_EN: C1 loads the PC only when zero_flag
// is set; otherwise a C1 request falls back to a plain increment.
module pcu_ctrl
   import pcu_pkg::*;
#(
   parameter logic [PC_W-1:0] PC_RESET = 8'h00,
   parameter int              MAX_WAIT = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            C0,
   input  logic            C1,
   input  logic            C5,
   input  logic            C6,
   input  logic            mem_we_sel,
   input  logic [2:0]      mux_sel,
   input  logic [PC_W-1:0] alu_out,
   input  logic            zero_flag,
   input  logic [PC_W-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic [PC_W-1:0] TDB,
   output logic [PC_W-1:0] mem_addr,
   output logic [PC_W-1:0] mem_wdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic            stall,
   output logic            bus_err,
   output logic [PC_W-1:0] PC
);

   logic [PC_W-1:0] mar;
   logic [PC_W-1:0] mdr;
   logic            mdr_load;

   pcu_bus_fsm #(
      .MAX_WAIT (MAX_WAIT)
   ) u_bus_fsm (
      .clock      (clock),
      .reset      (reset),
      .C6         (C6),
      .mem_we_sel (mem_we_sel),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .stall      (stall),
      .bus_err    (bus_err),
      .mdr_load   (mdr_load)
   );

   // Internal data bus source select; unused codes drive zero.
   always_comb begin
      TDB = '0;
      case (mux_sel_e'(mux_sel))
         SEL_MDR: TDB = mdr;
         SEL_PC:  TDB = PC;
         SEL_ALU: TDB = alu_out;
         SEL_MEM: TDB = mem_rdata;
         default: TDB = '0;
      endcase
   end

`ifdef PCU_COND_BRANCH_EN
   // Program counter: a load only happens on a taken branch (zero_flag);
   // an untaken C1 or a plain C0 advances to the next instruction.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         PC <= PC_RESET;
      end else if (!stall) begin
         if (C1 && zero_flag) begin
            PC <= TDB;
         end else if (C1 || C0) begin
            PC <= PC + 8'd1;
         end
      end
   end
`else
   logic unused_zero_flag;
   assign unused_zero_flag = zero_flag;

   // Program counter: load from TDB wins over increment; frozen in stall.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         PC <= PC_RESET;
      end else if (!stall) begin
         if (C1) begin
            PC <= TDB;
         end else if (C0) begin
            PC <= PC + 8'd1;
         end
      end
   end
`endif

   // Memory address register, frozen while an access is in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mar <= '0;
      end else if (C5 && !stall) begin
         mar <= TDB;
      end
   end

   // Memory data register, written only by a completed read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mdr <= '0;
      end else if (mdr_load) begin
         mdr <= mem_rdata;
      end
   end

   assign mem_addr  = mar;
   assign mem_wdata = mdr;

endmodule

// File: tb/tb_pcu_ctrl.sv
// Self-checking bench for pcu_ctrl: directed scenarios plus randomized
// cycles, all compared against a transaction-level reference model.
module tb_pcu_ctrl;

   localparam logic [7:0] PC_RESET = 8'h00;
   localparam int         MAX_WAIT = 4;

   logic       clock;
   logic       reset;
   logic       c0, c1, c5, c6, we_sel;
   logic [2:0] sel;
   logic [7:0] alu, rdata;
   logic       ready, zf;

   logic [7:0] TDB, mem_addr, mem_wdata, PC;
   logic       mem_req, mem_we, stall, bus_err;

   int check_count = 0;
   int pass_count  = 0;

   // Reference model: architectural registers plus the progress of the
   // current memory transaction.
   logic [7:0] m_pc, m_mar, m_mdr;
   bit         m_in_access, m_turnaround, m_we, m_err;
   int         m_waits;

   pcu_ctrl #(
      .PC_RESET (PC_RESET),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .C0         (c0),
      .C1         (c1),
      .C5         (c5),
      .C6         (c6),
      .mem_we_sel (we_sel),
      .mux_sel    (sel),
      .alu_out    (alu),
      .zero_flag  (zf),
      .mem_rdata  (rdata),
      .mem_ready  (ready),
      .TDB        (TDB),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .stall      (stall),
      .bus_err    (bus_err),
      .PC         (PC)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Guard against a hung run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] expected);
      check_count++;
      if (got === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, expected, $time);
      end
   endtask

   function automatic logic [7:0] modelTdb();
      case (sel)
         3'd0:    return m_mdr;
         3'd1:    return m_pc;
         3'd2:    return alu;
         3'd3:    return rdata;
         default: return 8'h00;
      endcase
   endfunction

   task automatic modelReset();
      m_pc = PC_RESET; m_mar = 8'h00; m_mdr = 8'h00;
      m_in_access = 0; m_turnaround = 0; m_we = 0; m_err = 0; m_waits = 0;
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   task automatic modelStep();
      logic [7:0] bus;
      bus = modelTdb();
      if (m_in_access) begin
         if (ready) begin
            if (!m_we) m_mdr = rdata;
            m_in_access  = 0;
            m_turnaround = 1;
         end else begin
            m_waits++;
            if (m_waits >= MAX_WAIT) begin
               m_err        = 1;
               m_in_access  = 0;
               m_turnaround = 1;
            end
         end
      end else if (m_turnaround) begin
         m_turnaround = 0;
      end else begin
`ifdef PCU_COND_BRANCH_EN
         if (c1 && zf)       m_pc = bus;
         else if (c1 || c0)  m_pc = m_pc + 8'd1;
`else
         if (c1)             m_pc = bus;
         else if (c0)        m_pc = m_pc + 8'd1;
`endif
         if (c5) m_mar = bus;
         if (c6) begin
            m_in_access = 1;
            m_we        = we_sel;
            m_waits     = 0;
         end
      end
   endtask

   // Apply one cycle of inputs at the negedge, check the bus, clock it
   // through and compare every registered output with the model.
   task automatic applyStimulus(input logic i_c0, input logic i_c1, input logic i_c5,
                                input logic i_c6, input logic i_we, input logic [2:0] i_sel,
                                input logic [7:0] i_alu, input logic [7:0] i_rd,
                                input logic i_ready, input logic i_zf);
      c0 = i_c0; c1 = i_c1; c5 = i_c5; c6 = i_c6; we_sel = i_we;
      sel = i_sel; alu = i_alu; rdata = i_rd; ready = i_ready; zf = i_zf;
      #1;
      checkOutput("tdb", TDB, modelTdb());
      modelStep();
      @(posedge clock);
      #1;
      checkOutput("pc", PC, m_pc);
      checkOutput("mem_addr", mem_addr, m_mar);
      checkOutput("mdr", mem_wdata, m_mdr);
      checkOutput("mem_req", 8'(mem_req), 8'(m_in_access));
      checkOutput("stall", 8'(stall), 8'(m_in_access | m_turnaround));
      checkOutput("bus_err", 8'(bus_err), 8'(m_err));
      if (m_in_access) checkOutput("mem_we", 8'(mem_we), 8'(m_we));
      @(negedge clock);
   endtask

   // Start an access and run it to completion; waits < 0 means memory
   // never answers. Returns the number of sampled stall-high cycles.
   task automatic runAccess(input logic a_we, input logic a_c0, input int waits,
                            input logic [7:0] a_rd, output int cycles);
      int k;
      applyStimulus(a_c0, 1'b0, 1'b0, 1'b1, a_we, 3'd2, 8'hEE, a_rd, 1'b0, 1'b0);
      cycles = 0;
      k = 0;
      while (stall === 1'b1 && k < 20) begin
         cycles++;
         applyStimulus(a_c0, 1'b0, 1'b1, 1'b1, ~a_we, 3'd2, 8'hEE, a_rd,
                       (waits >= 0 && k >= waits), 1'b0);
         k++;
      end
      if (k >= 20) checkOutput("stall_bound", 8'(k), 8'd0);
   endtask

   initial begin
      int         cycles;
      logic [7:0] pc_before;

      reset = 1'b0;
      c0 = 0; c1 = 0; c5 = 0; c6 = 0; we_sel = 0;
      sel = 3'd0; alu = 8'h00; rdata = 8'h00; ready = 0; zf = 0;
      modelReset();
      repeat (2) @(negedge clock);
      checkOutput("rst_pc", PC, PC_RESET);
      checkOutput("rst_mem_addr", mem_addr, 8'h00);
      checkOutput("rst_mdr", mem_wdata, 8'h00);
      checkOutput("rst_mem_req", 8'(mem_req), 8'h00);
      checkOutput("rst_stall", 8'(stall), 8'h00);
      checkOutput("rst_bus_err", 8'(bus_err), 8'h00);
      reset = 1'b1;

      // Increment three times from reset.
      repeat (3) applyStimulus(1, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, 1, 0);
      checkOutput("pc_inc3", PC, 8'h03);

      // Wrap from FF to 00.
      applyStimulus(0, 1, 0, 0, 0, 3'd2, 8'hFF, 8'h00, 1, 1);
      applyStimulus(1, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, 1, 0);
      checkOutput("pc_wrap", PC, 8'h00);

      // Load beats increment when both asserted.
      applyStimulus(1, 1, 0, 0, 0, 3'd2, 8'h5A, 8'h00, 1, 1);
      checkOutput("pc_load_prio", PC, 8'h5A);
      applyStimulus(1, 1, 0, 0, 0, 3'd2, 8'h33, 8'h00, 1, 0);
`ifdef PCU_COND_BRANCH_EN
      checkOutput("pc_cond_untaken", PC, 8'h5B);
`else
      checkOutput("pc_uncond_load", PC, 8'h33);
`endif

      // MAR load then zero-wait read.
      applyStimulus(0, 0, 1, 0, 0, 3'd2, 8'h20, 8'h00, 1, 0);
      runAccess(1'b0, 1'b0, 0, 8'hC3, cycles);
      checkOutput("rd_addr", mem_addr, 8'h20);
      checkOutput("rd_mdr", mem_wdata, 8'hC3);
      checkOutput("rd_stall_len", 8'(cycles), 8'd2);

      // Write with two wait states; C0 held throughout.
      pc_before = m_pc;
      runAccess(1'b1, 1'b1, 2, 8'h11, cycles);
      checkOutput("wr_stall_len", 8'(cycles), 8'd4);
      checkOutput("wr_pc_frozen", PC, pc_before + 8'd1);
      checkOutput("wr_mdr_kept", mem_wdata, 8'hC3);

      // Timeout: memory never answers.
      runAccess(1'b0, 1'b0, -1, 8'hAA, cycles);
      checkOutput("to_stall_len", 8'(cycles), 8'd5);
      checkOutput("to_bus_err", 8'(bus_err), 8'h01);
      checkOutput("to_mdr_kept", mem_wdata, 8'hC3);
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 3'd1, 8'h00, 8'h00, 1, 0);
      checkOutput("to_err_sticky", 8'(bus_err), 8'h01);

      // Asynchronous reset in the middle of an access.
      applyStimulus(0, 1, 0, 0, 0, 3'd2, 8'h77, 8'h00, 1, 1);
      applyStimulus(1, 0, 0, 1, 0, 3'd1, 8'h00, 8'h00, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 3'd1, 8'h00, 8'h00, 0, 0);
      checkOutput("mid_req_before", 8'(mem_req), 8'h01);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_mem_req", 8'(mem_req), 8'h00);
      checkOutput("async_pc", PC, PC_RESET);
      checkOutput("async_stall", 8'(stall), 8'h00);
      checkOutput("async_bus_err", 8'(bus_err), 8'h00);
      checkOutput("async_mdr", mem_wdata, 8'h00);
      modelReset();
      @(negedge clock);
      reset = 1'b1;

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom),
                       ($urandom_range(0, 2) == 0), 1'($urandom), 3'($urandom),
                       8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom));
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
